// File: rtl/mc_muldiv_if.sv
// Handshake and operand bundle for mc_muldiv: the requester drives start/abort/operands,
// the unit returns busy/done/result.
interface mc_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            abort;
  logic [2:0]      func3;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, abort, func3, opa, opb,
    input  busy, done, result
  );

  modport slave (
    input  start, abort, func3, opa, opb,
    output busy, done, result
  );
endinterface

// File: rtl/mc_muldiv.sv
// Iterative RV32M/RV64M-style multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional macro MULDIV_FAST_EN adds a one-cycle early-out for divide-by-zero, signed overflow and zero multiplies.
module mc_muldiv #(
  parameter int XLEN = 32
) (
  input logic        clk,
  input logic        rst,
  mc_muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op;
  logic [XLEN-1:0]   opa_raw;
  logic [XLEN-1:0]   addend;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic              neg_a, neg_b, div_zero, ovf;
  logic              accept, last_step, early, early_mul;

  // Operand decode, only meaningful on the accepting edge
  logic            a_sgn, b_sgn, in_neg_a, in_neg_b, ovf_in;
  logic [XLEN-1:0] amag_in, bmag_in;

  always_comb begin
    a_sgn    = !(bus.func3 inside {3'b011, 3'b101, 3'b111});
    b_sgn    = !(bus.func3 inside {3'b010, 3'b011, 3'b101, 3'b111});
    in_neg_a = a_sgn & bus.opa[XLEN-1];
    in_neg_b = b_sgn & bus.opb[XLEN-1];
    amag_in  = in_neg_a ? -bus.opa : bus.opa;
    bmag_in  = in_neg_b ? -bus.opb : bus.opb;
    ovf_in   = (bus.func3 inside {3'b100, 3'b110}) &&
               (bus.opa == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.opb);
  end

  assign accept    = (state != CALC) && bus.start && !bus.abort;
  assign last_step = (cnt == CW'(XLEN - 1));

`ifdef MULDIV_FAST_EN
  logic mul_zero;
  assign early_mul = mul_zero;
  assign early     = op[2] ? (div_zero || ovf) : mul_zero;
`else
  assign early_mul = 1'b0;
  assign early     = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && !bus.abort) state_nxt = CALC;
      CALC:    if (bus.abort)                 state_nxt = IDLE;
               else if (last_step || early)   state_nxt = FIN;
      FIN:     if (bus.start && !bus.abort)   state_nxt = CALC;
               else                           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == CALC);
    bus.done = (state == FIN);
  end

  // One iteration: multiply adds and shifts right; divide shifts left and trial-subtracts
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, addend} : '0);
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, addend};
    if (op[2]) begin
      if (!diff[XLEN]) acc_step = {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};
      else             acc_step = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Sign application and special-case fixup on the final iteration's value
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fin_val;

  always_comb begin
    prod = (neg_a ^ neg_b) ? -acc_step : acc_step;
    quo  = (neg_a ^ neg_b) ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = neg_a ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op)
      3'b000:                 fin_val = early_mul ? '0 : prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_val = early_mul ? '0 : prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_val = div_zero ? '1 :
                                        ovf ? {1'b1, {(XLEN-1){1'b0}}} : quo;
      default:                fin_val = div_zero ? opa_raw : ovf ? '0 : rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op         <= '0;
      opa_raw    <= '0;
      addend     <= '0;
      acc        <= '0;
      cnt        <= '0;
      neg_a      <= 1'b0;
      neg_b      <= 1'b0;
      div_zero   <= 1'b0;
      ovf        <= 1'b0;
      bus.result <= '0;
`ifdef MULDIV_FAST_EN
      mul_zero   <= 1'b0;
`endif
    end else if (accept) begin
      op       <= bus.func3;
      opa_raw  <= bus.opa;
      neg_a    <= in_neg_a;
      neg_b    <= in_neg_b;
      div_zero <= (bus.opb == '0);
      ovf      <= ovf_in;
      cnt      <= '0;
      // Multiply keeps the multiplier in the low half; divide keeps the dividend there
      acc      <= {{XLEN{1'b0}}, bus.func3[2] ? amag_in : bmag_in};
      addend   <= bus.func3[2] ? bmag_in : amag_in;
`ifdef MULDIV_FAST_EN
      mul_zero <= (bus.opa == '0) || (bus.opb == '0);
`endif
    end else if (state == CALC && !bus.abort) begin
      acc <= acc_step;
      cnt <= cnt + 1'b1;
      if (last_step || early) bus.result <= fin_val;
    end
  end
endmodule

// File: tb/tb_mc_muldiv.sv
// Self-checking bench for mc_muldiv (XLEN=32): directed RV M cases, randomized ops against
// an arithmetic reference model, abort, start-in-CALC, mid-operation reset and back-to-back starts.
module tb_mc_muldiv;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mc_muldiv_if #(.XLEN(XLEN)) bus ();
  mc_muldiv #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges counted from the accepting edge (edge 1) to the edge after which done is seen
  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_EN
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
    if (!f[2] && (a == 0 || b == 0)) return 2;
`endif
    return XLEN + 1;
  endfunction

  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.func3 = f;
    bus.opa   = a;
    bus.opb   = b;
    bus.start = 1'b1;
    bus.abort = 1'b0;
  endtask

  // Called at the negedge where start was driven; returns at the negedge showing done
  task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat);
    int edges, nbusy;
    bit seen;
    @(negedge clk);
    bus.start = 1'b0;
    edges = 1;
    nbusy = 0;
    seen  = 1'b0;
    check({tag, "_busy_on_accept"}, bus.busy, 1);
    while (edges < exp_lat + 8) begin
      if (bus.done) begin seen = 1'b1; break; end
      if (bus.busy) nbusy++;
      @(negedge clk);
      edges++;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, edges, exp_lat);
    check({tag, "_busy_cycles"}, nbusy, exp_lat - 1);
    check({tag, "_result"}, bus.result, exp_res);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res);
    start_op(f, a, b);
    wait_done(tag, exp_res, latency(f, a, b));
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_result_hold"}, bus.result, exp_res);
  endtask

  initial begin
    logic [2:0]  f, f2;
    logic [31:0] a, b, a2, b2, held;
    int          ndone, edges;
    bit          seen;

    rst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.func3 = '0;
    bus.opa   = '0;
    bus.opb   = '0;
    #3;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_result", bus.result, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases with hand-computed results
    run_op("mul_7_m3",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulhu_max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu_m1",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    run_op("divu_100_7",  3'd5, 32'd100,        32'd7,         32'd14);
    run_op("remu_100_7",  3'd7, 32'd100,        32'd7,         32'd2);
    run_op("divu_by0",    3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF);
    run_op("rem_by0",     3'd6, 32'd5,          32'd0,         32'd5);
    run_op("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
    run_op("mul_zero",    3'd1, 32'd0,          32'h1234_5678, 32'd0);

    // Randomized operations against the reference model, biased toward corner operands
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 9))
        0: b = '0;
        1: a = '0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, model(f, a, b));
    end

    // Abort on the 10th CALC cycle: back to IDLE, no done, result untouched
    held = model(3'd5, 32'd100, 32'd7);
    run_op("pre_abort", 3'd5, 32'd100, 32'd7, held);
    start_op(3'd4, 32'd1000, 32'd7);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_result", bus.result, held);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort_no_done", ndone, 0);

    // Abort in IDLE beats a simultaneous start
    start_op(3'd0, 32'd3, 32'd3);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_idle_busy", bus.busy, 0);

    // Abort in FIN beats a simultaneous start
    start_op(3'd0, 32'd6, 32'd7);
    wait_done("pre_fin_abort", 32'd42, latency(3'd0, 32'd6, 32'd7));
    start_op(3'd0, 32'd9, 32'd9);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_fin_busy", bus.busy, 0);
    check("abort_fin_done", bus.done, 0);
    check("abort_fin_result", bus.result, 42);

    // A start raised during CALC must not disturb the operation in flight
    start_op(3'd5, 32'd100, 32'd7);
    @(negedge clk);
    bus.start = 1'b0;
    edges = 1;
    repeat (4) begin @(negedge clk); edges++; end
    start_op(3'd0, 32'd3, 32'd5);
    seen = 1'b0;
    while (edges < XLEN + 10) begin
      @(negedge clk);
      bus.start = 1'b0;
      edges++;
      if (bus.done) begin seen = 1'b1; break; end
    end
    check("calc_start_done_seen", seen, 1);
    check("calc_start_latency", edges, XLEN + 1);
    check("calc_start_result", bus.result, 32'd14);
    @(negedge clk);
    check("calc_start_not_queued", bus.busy, 0);

    // Reset mid-CALC clears outputs without waiting for a clock
    start_op(3'd0, 32'd5, 32'd5);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_result", bus.result, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op("post_rst_div", 3'd4, 32'hFFFF_FF9C, 32'd7, model(3'd4, 32'hFFFF_FF9C, 32'd7));

    // Back-to-back: start held in FIN goes straight to CALC
    f = 3'd1; a = $urandom(); b = $urandom();
    f2 = 3'd7; a2 = $urandom(); b2 = 32'($urandom_range(1, 1000));
    start_op(f, a, b);
    wait_done("b2b_first", model(f, a, b), latency(f, a, b));
    start_op(f2, a2, b2);
    wait_done("b2b_second", model(f2, a2, b2), latency(f2, a2, b2));
    @(negedge clk);
    check("b2b_end_done", bus.done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mc_muldiv.md
MC_MULDIV -- requirements
Module: mc_muldiv

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width (legal: 8..64, even).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port abort, input, 1 bit: synchronous flush of the operation in flight.
REQ-006 The block SHALL have port func3, input, 3 bits: operation select, RV M encoding (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 The block SHALL have port opa, input, XLEN bits: rs1 operand (multiplicand or dividend).
REQ-008 The block SHALL have port opb, input, XLEN bits: rs2 operand (multiplier or divisor).
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-011 The block SHALL have port result, output, XLEN bits: result of the last completed operation.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and FIN: IDLE->CALC on start; CALC->FIN when the step counter reaches its last step; FIN->IDLE, or FIN->CALC when start is high in FIN.
REQ-013 start SHALL be accepted only in IDLE or FIN; func3, opa and opb SHALL be latched on the accepting edge; start in CALC SHALL be ignored.
REQ-014 busy SHALL be high exactly while the state is CALC; done SHALL be high exactly while the state is FIN.
REQ-015 Multiply SHALL use iterative shift-add, one bit per cycle, on XLEN-bit magnitudes with a 2*XLEN-bit product; the sign SHALL be applied at completion.
REQ-016 MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2*XLEN-1:XLEN] with signed/signed, signed/unsigned and unsigned/unsigned operand interpretation respectively.
REQ-017 Divide SHALL use restoring division, one quotient bit per cycle, on magnitudes; the quotient sign SHALL be sign(opa) XOR sign(opb); the remainder sign SHALL equal sign(opa).
REQ-018 Divide by zero SHALL give quotient all-ones (DIV, DIVU) and remainder = opa unmodified (REM, REMU).
REQ-019 Signed overflow (opa = -2^(XLEN-1), opb = -1) SHALL give DIV = -2^(XLEN-1) and REM = 0.
REQ-020 Latency SHALL be: done high in the cycle following the (XLEN+1)th rising edge after the edge that accepted start (base build).
REQ-021 result SHALL update only on entry to FIN and SHALL hold until the next entry to FIN.
REQ-022 abort in CALC SHALL force IDLE on the next edge with no done pulse and result unchanged; abort in IDLE or FIN SHALL force IDLE and SHALL win over a simultaneous start.
REQ-023 The step counter SHALL be ceil(log2(XLEN+1)) bits wide and SHALL never wrap within one operation.

Reset
REQ-024 While rst is low: state = IDLE, busy = 0, done = 0, result = 0, internal accumulators and counter = 0, taking effect immediately without a clock.
REQ-025 Reset asserted mid-operation SHALL discard the operation; after release, the first accepted start SHALL behave as a fresh operation.

Configuration
REQ-026 Macro MULDIV_FAST_EN, when defined, SHALL enable an early-out: divide by zero, signed overflow, or either multiply operand equal to zero SHALL go CALC->FIN after one CALC cycle, so done is high in the cycle after the 2nd edge following acceptance.
REQ-027 Without MULDIV_FAST_EN, every operation SHALL take the full REQ-020 latency, and the special cases SHALL be resolved by fixup at completion with identical result values.

Verification (XLEN=32)
REQ-028 MUL, opa=7, opb=-3 -> result 0xFFFFFFEB; done in the cycle after the 33rd edge following acceptance; busy high for 32 cycles.
REQ-029 MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU, opa=-1, opb=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 DIV, -7 / 2 -> -3 (0xFFFFFFFD); REM, -7 % 2 -> -1; DIVU, 100 / 7 -> 14; REMU, 100 % 7 -> 2.
REQ-031 DIVU, 5 / 0 -> 0xFFFFFFFF; REM, 5 % 0 -> 5; DIV, 0x80000000 / 0xFFFFFFFF -> 0x80000000 with REM 0; with MULDIV_FAST_EN each completes in 2 edges.
REQ-032 start DIV, assert abort on the 10th cycle of CALC -> IDLE next edge, no done pulse, result still the prior value; start asserted in CALC -> ignored.
REQ-033 rst pulled low mid-CALC -> busy, done and result are 0 asynchronously; back-to-back start in FIN -> second operation is accepted with no IDLE cycle between.
